multicast_tree: RTL

- Egress-side counterpart of the reduction tree in the MPI collective router: takes one flit stream and replicates each flit to a per-flit subset of FAN_OUT output ports (multicast/broadcast leg of a collective).
- Buffers up to QUEUE_DEPTH flits.
- Forks partially: each selected port takes its copy independently, and the head flit retires only when every selected port has taken it.

---
 rtl/collective_pkg.sv | 36 +++
 rtl/multicast_fifo.sv | 66 ++++++
 rtl/multicast_tree.sv | 102 ++++++++++
 3 files changed

// File: rtl/collective_pkg.sv
// collective_pkg
//   Definitions shared by the collective router blocks (reduction_tree,
//   multicast_tree and the router top): flit geometry, port count,
//   port direction encodings, flit field offsets and a sizing helper.
package collective_pkg;

    localparam int FLIT_SIZE = 82;
    localparam int PORT_NUM  = 6;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_SOUTH = 3'd2,
        DIR_EAST  = 3'd3,
        DIR_WEST  = 3'd4,
        DIR_UP    = 3'd5
    } dir_e;

    // Flit layout, LSB first: payload | source | opcode | tag | type
    localparam int FLIT_PAYLOAD_LSB = 0;
    localparam int FLIT_PAYLOAD_W   = 64;
    localparam int FLIT_SRC_LSB     = 64;
    localparam int FLIT_SRC_W       = 8;
    localparam int FLIT_OP_LSB      = 72;
    localparam int FLIT_OP_W        = 4;
    localparam int FLIT_TAG_LSB     = 76;
    localparam int FLIT_TAG_W       = 4;
    localparam int FLIT_TYPE_LSB    = 80;
    localparam int FLIT_TYPE_W      = 2;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/multicast_fifo.sv
// multicast_fifo
//   Circular buffer of {flit, destination mask} entries for multicast_tree.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     push            write push_flit/push_mask at the tail (caller ensures not full)
//     push_flit/mask  entry to write
//     pop             advance the head (caller ensures not empty)
//     count           occupancy, 0..QUEUE_DEPTH
//     head_flit       flit stored at the head entry
//     next_mask       mask stored one entry behind the head
//   Storage is not reset; only pointers and count are.
module multicast_fifo
    import collective_pkg::*;
#(
    parameter int FLIT_SIZE   = 82,
    parameter int FAN_OUT     = 6,
    parameter int QUEUE_DEPTH = 4,
    localparam int CNT_W      = cnt_w(QUEUE_DEPTH),
    localparam int PTR_W      = $clog2(QUEUE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [FLIT_SIZE-1:0] push_flit,
    input  logic [FAN_OUT-1:0]   push_mask,
    input  logic                 pop,
    output logic [CNT_W-1:0]     count,
    output logic [FLIT_SIZE-1:0] head_flit,
    output logic [FAN_OUT-1:0]   next_mask
);

    logic [FLIT_SIZE-1:0] flit_mem [QUEUE_DEPTH];
    logic [FAN_OUT-1:0]   mask_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_ptr_nxt;

    // Depth is a power of two, so pointer arithmetic wraps for free.
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    assign head_flit  = flit_mem[rd_ptr];
    assign next_mask  = mask_mem[rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[wr_ptr] <= push_flit;
            mask_mem[wr_ptr] <= push_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multicast_tree.sv
// multicast_tree
//   Replicates each incoming flit to the subset of FAN_OUT ports named by
//   its mask. Each selected port takes its copy independently; the head
//   entry retires once every selected port has taken it.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     in         flit to replicate
//     in_mask    destination mask for in (bit i = port i)
//     in_valid   in/in_mask valid
//     in_avail   a flit can be accepted this cycle
//     out        per-port flit, slice i = [FLIT_SIZE*i +: FLIT_SIZE]
//     out_valid  per-port valid
//     out_avail  per-port downstream ready
//   QUEUE_DEPTH must be a power of two and at least 2.
module multicast_tree
    import collective_pkg::*;
#(
    parameter int FAN_OUT     = collective_pkg::PORT_NUM,
    parameter int FLIT_SIZE   = collective_pkg::FLIT_SIZE,
    parameter int QUEUE_DEPTH = 4,
    localparam int CNT_W      = cnt_w(QUEUE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_SIZE-1:0]         in,
    input  logic [FAN_OUT-1:0]           in_mask,
    input  logic                         in_valid,
    output logic                         in_avail,
    output logic [FLIT_SIZE*FAN_OUT-1:0] out,
    output logic [FAN_OUT-1:0]           out_valid,
    input  logic [FAN_OUT-1:0]           out_avail
);

    logic [CNT_W-1:0]     count;
    logic [FLIT_SIZE-1:0] head_flit;
    logic [FLIT_SIZE-1:0] shown_flit;
    logic [FAN_OUT-1:0]   next_mask;
    logic [FAN_OUT-1:0]   pending;
    logic [FAN_OUT-1:0]   pending_next;
    logic [FAN_OUT-1:0]   pending_load;
    logic                 nonempty;
    logic                 accept;
    logic                 push;
    logic                 retire;

    multicast_fifo #(
        .FLIT_SIZE   (FLIT_SIZE),
        .FAN_OUT     (FAN_OUT),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_flit (in),
        .push_mask (in_mask),
        .pop       (retire),
        .count     (count),
        .head_flit (head_flit),
        .next_mask (next_mask)
    );

    assign nonempty = (count != '0);

    // Depends only on reset and the registered count, so a retire in the
    // same cycle never reopens a full buffer early.
    assign in_avail = rst && (count != CNT_W'(QUEUE_DEPTH));

    assign accept = in_valid && in_avail;
    // Zero-mask flits are consumed but never stored.
    assign push   = accept && (in_mask != '0);

    assign out_valid    = nonempty ? pending : '0;
    assign pending_next = pending & ~(out_valid & out_avail);
    assign retire       = nonempty && (pending_next == '0);

    // Empty buffer shows zero rather than stale storage, which also makes
    // out drop to zero as soon as reset clears count.
    assign shown_flit = nonempty ? head_flit : '0;
    assign out        = {FAN_OUT{shown_flit}};

    always_comb begin
        pending_load = pending_next;
        if (retire) begin
            if (count >= CNT_W'(2))
                pending_load = next_mask;
            else if (push)
                pending_load = in_mask;   // new flit becomes head as old one leaves
            else
                pending_load = '0;
        end else if (!nonempty && push) begin
            pending_load = in_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= pending_load;
    end

endmodule
